// File: rtl/pool2_ofm_buffer.sv
// Pool2 output feature-map buffer: captures 16 pooled 5x5 maps written three
// channels per beat, stores them flattened (channel*AREA + pixel) and serves
// them to the next layer through a 1-cycle-latency read port.
module pool2_ofm_buffer #(
  parameter int DATA_WIDTH        = 32,
  parameter int IFM_SIZE          = 5,
  parameter int IFM_DEPTH         = 16,
  parameter int LANES             = 3,
  parameter int ADDRESS_SIZE      = $clog2(IFM_SIZE*IFM_SIZE),
  parameter int READ_ADDRESS_SIZE = $clog2(IFM_DEPTH*IFM_SIZE*IFM_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        data_in_from_previous1,
  input  logic [DATA_WIDTH-1:0]        data_in_from_previous2,
  input  logic [DATA_WIDTH-1:0]        data_in_from_previous3,
  input  logic [ADDRESS_SIZE-1:0]      ifm_address_write_previous,
  input  logic                         ifm_enable_write_previous,
  input  logic                         start_from_previous,
  output logic                         end_to_previous,
  output logic                         start_to_next,
  input  logic                         end_from_next,
  input  logic                         ifm_enable_read_next,
  input  logic [READ_ADDRESS_SIZE-1:0] ifm_address_read_next,
  output logic [DATA_WIDTH-1:0]        data_out_for_next,
  output logic                         overflow
);

  localparam int AREA   = IFM_SIZE * IFM_SIZE;
  localparam int GROUPS = (IFM_DEPTH + LANES - 1) / LANES;
  localparam int WORDS  = IFM_DEPTH * AREA;
  localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {READY, LOADING, FULL} state_t;

  state_t                 state;
  logic [G_W-1:0]         grp;
  logic                   all_groups;

  logic [DATA_WIDTH-1:0]  mem [WORDS];

  logic [DATA_WIDTH-1:0]        lane_data [LANES];
  logic [READ_ADDRESS_SIZE-1:0] lane_idx  [LANES];
  logic                         lane_ok   [LANES];

  logic wr_addr_ok;
  logic wr_accept;
  logic wr_reject;
  logic last_beat;
  logic rd_addr_ok;

  assign lane_data[0] = data_in_from_previous1;
  assign lane_data[1] = data_in_from_previous2;
  assign lane_data[2] = data_in_from_previous3;

  // Once every group has landed, further beats would wrap over stored maps.
  assign wr_addr_ok = int'(ifm_address_write_previous) < AREA;
  assign wr_accept  = ifm_enable_write_previous && (state != FULL) && wr_addr_ok && !all_groups;
  assign wr_reject  = ifm_enable_write_previous && !wr_accept;
  assign last_beat  = wr_accept && (int'(ifm_address_write_previous) == AREA - 1);
  assign rd_addr_ok = int'(ifm_address_read_next) < WORDS;

  // Per-lane flattened target address; lanes past the last channel are dropped.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      int chan;
      chan        = LANES * int'(grp) + k;
      lane_ok[k]  = chan < IFM_DEPTH;
      lane_idx[k] = READ_ADDRESS_SIZE'(chan * AREA + int'(ifm_address_write_previous));
    end
  end

  // Storage write: one port per lane, contents never cleared.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_accept && lane_ok[k]) begin
        mem[lane_idx[k]] <= lane_data[k];
      end
    end
  end

  // Read port: served only while the buffer is full; out-of-range reads give 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_for_next <= '0;
    end else if (ifm_enable_read_next && state == FULL) begin
      data_out_for_next <= rd_addr_ok ? mem[ifm_address_read_next] : '0;
    end
  end

  // Layer handshake FSM, group counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= READY;
      end_to_previous <= 1'b1;
      start_to_next   <= 1'b0;
      overflow        <= 1'b0;
      grp             <= '0;
      all_groups      <= 1'b0;
    end else begin
      start_to_next <= 1'b0;
      if (wr_reject) begin
        overflow <= 1'b1;
      end
      if (last_beat) begin
        if (int'(grp) == GROUPS - 1) begin
          all_groups <= 1'b1;
        end else begin
          grp <= grp + 1'b1;
        end
      end
      case (state)
        READY: begin
          if (start_from_previous) begin
            state           <= FULL;
            end_to_previous <= 1'b0;
            start_to_next   <= 1'b1;
          end else if (wr_accept) begin
            state           <= LOADING;
            end_to_previous <= 1'b0;
          end
        end
        LOADING: begin
          if (start_from_previous) begin
            state         <= FULL;
            start_to_next <= 1'b1;
          end
        end
        FULL: begin
          if (start_from_previous) begin
            overflow <= 1'b1;
          end
          if (end_from_next) begin
            state           <= READY;
            end_to_previous <= 1'b1;
            grp             <= '0;
            all_groups      <= 1'b0;
          end
        end
        default: begin
          state           <= READY;
          end_to_previous <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool2_ofm_buffer.sv
// Self-checking bench for pool2_ofm_buffer: loads whole layers, then reads
// every word back through a scoreboard queue of expected read data.
module tb_pool2_ofm_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d1, d2, d3;
  logic [4:0]  waddr;
  logic        wen;
  logic        start_prev;
  logic        end_to_previous;
  logic        start_to_next;
  logic        end_from_next;
  logic        ren;
  logic [8:0]  raddr;
  logic [31:0] dout;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  pool2_ofm_buffer dut (
    .clk                        (clk),
    .reset                      (reset),
    .data_in_from_previous1     (d1),
    .data_in_from_previous2     (d2),
    .data_in_from_previous3     (d3),
    .ifm_address_write_previous (waddr),
    .ifm_enable_write_previous  (wen),
    .start_from_previous        (start_prev),
    .end_to_previous            (end_to_previous),
    .start_to_next              (start_to_next),
    .end_from_next              (end_from_next),
    .ifm_enable_read_next       (ren),
    .ifm_address_read_next      (raddr),
    .data_out_for_next          (dout),
    .overflow                   (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int off, input int i);
    if (i >= 400) return 32'd0;
    return 32'(off + 1000 * (i / 25) + (i % 25) + 1);
  endfunction

  task automatic write_beat(input int g, input int a, input int off, input bit with_start);
    d1         = 32'(off + 1000 * (3 * g + 0) + a + 1);
    d2         = 32'(off + 1000 * (3 * g + 1) + a + 1);
    d3         = 32'(off + 1000 * (3 * g + 2) + a + 1);
    waddr      = 5'(a);
    wen        = 1'b1;
    start_prev = with_start;
    tick();
    wen        = 1'b0;
    start_prev = 1'b0;
  endtask

  task automatic load(input int off, input int limit, input bit start_last);
    int beats;
    beats = 0;
    for (int g = 0; g < 6; g++) begin
      for (int a = 0; a < 25; a++) begin
        if (beats < limit) begin
          write_beat(g, a, off, start_last && g == 5 && a == 24);
          beats++;
        end
      end
    end
  endtask

  task automatic read_addr(input int a, input logic [31:0] e);
    logic [31:0] want;
    ren   = 1'b1;
    raddr = 9'(a);
    sb_q.push_back(e);
    tick();
    ren = 1'b0;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      want = sb_q.pop_front();
      check_eq($sformatf("rd%0d", a), dout, want);
    end
  endtask

  task automatic read_all(input int off);
    for (int i = 0; i < 400; i++) begin
      read_addr(i, exp_word(off, i));
    end
  endtask

  task automatic pulse_start();
    start_prev = 1'b1;
    tick();
    start_prev = 1'b0;
  endtask

  task automatic pulse_release();
    end_from_next = 1'b1;
    tick();
    end_from_next = 1'b0;
  endtask

  initial begin
    reset = 1'b1; d1 = '0; d2 = '0; d3 = '0; waddr = '0; wen = 1'b0;
    start_prev = 1'b0; end_from_next = 1'b0; ren = 1'b0; raddr = '0;
    tick();
    check_eq("rst_end_to_prev", 32'(end_to_previous), 32'd1);
    check_eq("rst_start_to_next", 32'(start_to_next), 32'd0);
    check_eq("rst_dout", dout, 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    tick();
    reset = 1'b0;

    // First layer, separate start pulse.
    load(0, 150, 1'b0);
    check_eq("load_end_to_prev", 32'(end_to_previous), 32'd0);
    check_eq("load_no_start", 32'(start_to_next), 32'd0);
    pulse_start();
    check_eq("start_pulse_hi", 32'(start_to_next), 32'd1);
    tick();
    check_eq("start_pulse_lo", 32'(start_to_next), 32'd0);
    read_all(0);
    read_addr(400, 32'd0);
    read_addr(449, 32'd0);
    read_addr(511, 32'd0);
    check_eq("ovf_after_load1", 32'(overflow), 32'd0);

    // Read latency and hold while enable is low.
    read_addr(26, 32'd1002);
    raddr = 9'd100;
    tick();
    tick();
    check_eq("rd_hold", dout, 32'd1002);

    // Release, then second layer with last beat coincident with start.
    pulse_release();
    check_eq("release_end_to_prev", 32'(end_to_previous), 32'd1);
    check_eq("release_start_lo", 32'(start_to_next), 32'd0);
    load(5000, 150, 1'b1);
    check_eq("sim_start_pulse", 32'(start_to_next), 32'd1);
    read_addr(399, 32'd20025);
    read_all(5000);
    check_eq("ovf_after_load2", 32'(overflow), 32'd0);

    // Write while full is dropped and flags overflow.
    d1 = 32'hDEAD; d2 = 32'hDEAD; d3 = 32'hDEAD; waddr = 5'd3; wen = 1'b1;
    tick();
    wen = 1'b0;
    check_eq("full_wr_ovf", 32'(overflow), 32'd1);
    read_addr(3, 32'd5004);
    tick();
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of loading.
    pulse_release();
    load(7000, 40, 1'b0);
    check_eq("midload_end_to_prev", 32'(end_to_previous), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_end_to_prev", 32'(end_to_previous), 32'd1);
    check_eq("mid_rst_start_to_next", 32'(start_to_next), 32'd0);
    check_eq("mid_rst_ovf", 32'(overflow), 32'd0);
    check_eq("mid_rst_dout", dout, 32'd0);
    load(9000, 150, 1'b0);
    pulse_start();
    check_eq("post_rst_start", 32'(start_to_next), 32'd1);
    read_all(9000);
    check_eq("post_rst_ovf", 32'(overflow), 32'd0);

    // Out-of-range write address while ready.
    pulse_release();
    d1 = 32'd1; waddr = 5'd30; wen = 1'b1;
    tick();
    wen = 1'b0;
    check_eq("bad_addr_ovf", 32'(overflow), 32'd1);
    check_eq("bad_addr_ready", 32'(end_to_previous), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool2_ofm_buffer.md
# pool2_ofm_buffer

Receiving end of the Pool2 output-write interface in the LeNet5 pipeline. Captures the 16 pooled 5x5 feature maps that TOP_Pool2 writes three channels at a time, stores them as one flattened 400-word map, and serves them to the next layer (FC1 / Conv3) through a single-port, 1-cycle-latency read interface. It drives the Pool2 `end_from_next` handshake and emits the layer-ready pulse to the consumer.

## Interface
- DATA_WIDTH, 32, word width (IEEE-754 single, opaque here)
- IFM_SIZE, 5, pooled map side; AREA = IFM_SIZE*IFM_SIZE = 25
- IFM_DEPTH, 16, channel count
- LANES, 3, channels per write beat; GROUPS = ceil(IFM_DEPTH/LANES) = 6
- ADDRESS_SIZE, $clog2(AREA) = 5, write address width
- READ_ADDRESS_SIZE, $clog2(IFM_DEPTH*AREA) = 9, flattened read address width

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- data_in_from_previous1..3  in  DATA_WIDTH each  lane 0..2 write data
- ifm_address_write_previous  in  ADDRESS_SIZE  pixel index 0..AREA-1
- ifm_enable_write_previous  in  1  write strobe, one beat per cycle
- start_from_previous  in  1  1-cycle pulse: layer complete
- end_to_previous  out  1  buffer empty and ready for a new layer
- start_to_next  out  1  1-cycle pulse: buffer full, readable
- end_from_next  in  1  1-cycle pulse: consumer finished, release buffer
- ifm_enable_read_next  in  1  read strobe
- ifm_address_read_next  in  READ_ADDRESS_SIZE  flattened index channel*AREA + pixel
- data_out_for_next  out  DATA_WIDTH  read data
- overflow  out  1  sticky error flag

## Operation
- Storage: IFM_DEPTH*AREA words, one write port per lane (or banked by channel mod LANES); contents never cleared.
- group counter g (0..GROUPS-1): lane k writes channel c = LANES*g + k at c*AREA + address; lanes with c >= IFM_DEPTH discarded (group 5: only lane 0 / channel 15 stored).
- g increments on an accepted write with address == AREA-1; at g == GROUPS-1 it saturates and sets `all_groups`.
- States:
  - READY: end_to_previous=1. Accepted write -> LOADING (that write committed). start_from_previous -> FULL (empty-layer case; stale data served).
  - LOADING: end_to_previous=0; writes accepted. start_from_previous -> FULL.
  - FULL: writes ignored and set overflow; reads served. end_from_next -> READY, g cleared, all_groups cleared.
- Write in LOADING/READY after all_groups set with address wrapping back to 0: ignored, overflow set.
- Write with address >= AREA: ignored, overflow set.
- start_from_previous while FULL: ignored, overflow set.
- end_from_next outside FULL: ignored, no flag.
- Reads outside FULL: data_out_for_next holds last value. Read address >= IFM_DEPTH*AREA in FULL: returns 0.
- overflow cleared only by reset.

## Timing
- Reset values: state READY, end_to_previous=1, start_to_next=0, data_out_for_next=0, overflow=0, g=0.
- Write: data visible to reads issued the cycle after the write edge.
- Same-cycle write and start_from_previous: write committed, state FULL next cycle.
- start_to_next: high exactly one cycle, the first cycle in FULL.
- Read latency 1: address/enable sampled at edge N, data_out_for_next valid after edge N, held until next accepted read.
- Same-cycle end_from_next and read in FULL: read served, then READY.
- end_to_previous rises the cycle after end_from_next is sampled.
- Reset mid-LOADING or mid-FULL: returns to reset values next edge; memory retained.

## Test plan
- Full load: 6 groups x 25 beats, lane k data = 1000*(3g+k) + addr + 1, then start pulse -> start_to_next one cycle; read all 400 addresses, word at c*25+p equals 1000c+p+1; channels 16,17 never written; overflow=0.
- Read latency: in FULL, read address 26 at cycle N -> data_out_for_next = 1002 (channel 1, pixel 1) after edge N, holds while enable low.
- Release: end_from_next pulse -> end_to_previous=1 next cycle; second layer with offset 5000 reads back 5000+... everywhere (g restarted at 0).
- Write while FULL at address 3 data 0xDEAD -> stored word unchanged, overflow=1 sticky.
- Simultaneous last write (g=5, addr 24) and start_from_previous -> word 399 = 15025, start_to_next next cycle.
- Reset asserted mid-LOADING after 40 beats -> end_to_previous=1, start_to_next=0, g=0; subsequent full load reads back correctly.
